// File: rtl/dm_rmw_ctrl_pkg.sv
// Shared encodings for the data-memory RMW controller: access sizes, exception codes, FSM states.
// No logic of its own; imported by the controller and its lane unit.
package dm_rmw_ctrl_pkg;

  localparam int unsigned DM_DEPTH_WORDS = 4096;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_MERGE,
    ST_FAULT,
    ST_RESP
  } dm_state_e;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
  } dm_req_t;

  // Size 3 arrives here already folded to SZ_WORD by the caller or hits the default arm.
  function automatic logic addr_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      default: return (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dm_rmw_ctrl_byte_lane.sv
// Combinational little-endian lane logic: extracts/extends a load lane from a read word and
//  merges store data into a base word. Zero latency, no flow control.
module byte_lane_unit
  import dm_rmw_ctrl_pkg::*;
(
  input  logic [31:0] i_rd_word,
  input  logic [31:0] i_base_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_sign,
  output logic [31:0] o_extracted,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte      = i_rd_word[{i_off, 3'b000} +: 8];
    w_half      = i_rd_word[{i_off[1], 4'b0000} +: 16];
    o_extracted = i_rd_word;
    o_merged    = i_base_word;
    case (i_size)
      SZ_BYTE: begin
        o_extracted = {{24{i_sign & w_byte[7]}}, w_byte};
        o_merged[{i_off, 3'b000} +: 8] = i_wdata[7:0];
      end
      SZ_HALF: begin
        o_extracted = {{16{i_sign & w_half[15]}}, w_half};
        o_merged[{i_off[1], 4'b0000} +: 16] = i_wdata[15:0];
      end
      default: begin
        o_extracted = i_rd_word;
        o_merged    = i_wdata;
      end
    endcase
  end

endmodule

// File: rtl/dm_rmw_ctrl.sv
// MEM-stage data-RAM controller: checks alignment/range, turns sub-word stores into RMW.
// Response 2 cycles after accept (3 for sub-word stores); req_ready low (stall) while busy.
module dm_rmw_ctrl
  import dm_rmw_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DM_DEPTH_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic [31:0] ram_now_pc,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_data,
  output logic        ram_isWD,
  input  logic [31:0] ram_out
);

  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

  dm_state_e   r_state;
  dm_state_e   w_next;
  dm_req_t     r_req;
  logic [31:0] r_merge_q;
  logic [31:0] r_resp_rdata;
  logic        r_exc_valid;
  logic [4:0]  r_exc_code;
  logic        w_fault;
  logic        w_sub_store;
  logic        w_wr_en;
  logic [1:0]  w_in_size;
  logic [31:0] w_extracted;
  logic [31:0] w_merged;

  assign w_in_size   = (req_size == 2'd3) ? SZ_WORD : req_size;
  assign w_fault     = addr_misaligned(w_in_size, req_addr[1:0]) | ({1'b0, req_addr} >= ADDR_LIMIT);
  assign w_sub_store = r_req.we & (r_req.size != SZ_WORD);

  byte_lane_unit u_lane (
    .i_rd_word   (ram_out),
    .i_base_word (r_merge_q),
    .i_wdata     (r_req.wdata),
    .i_off       (r_req.addr[1:0]),
    .i_size      (r_req.size),
    .i_sign      (r_req.sign),
    .o_extracted (w_extracted),
    .o_merged    (w_merged)
  );

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_wr_en = 1'b0;
    case (r_state)
      ST_IDLE:   if (req_valid) w_next = w_fault ? ST_FAULT : ST_ACCESS;
      ST_ACCESS: begin
        if (w_sub_store) begin
          w_next = ST_MERGE;
        end else begin
          w_next  = ST_RESP;
          w_wr_en = r_req.we;
        end
      end
      ST_MERGE: begin
        w_wr_en = 1'b1;
        w_next  = ST_RESP;
      end
      ST_FAULT:  w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Response registers are cleared on accept and after RESP so they only carry data in RESP.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_req        <= '0;
      r_merge_q    <= '0;
      r_resp_rdata <= '0;
      r_exc_valid  <= 1'b0;
      r_exc_code   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_req        <= '{we: req_we, size: w_in_size, sign: req_sign,
                              addr: req_addr, wdata: req_wdata, pc: req_pc};
            r_resp_rdata <= '0;
            r_exc_valid  <= 1'b0;
            r_exc_code   <= '0;
          end
        end
        ST_ACCESS: begin
          if (!r_req.we)       r_resp_rdata <= w_extracted;
          else if (w_sub_store) r_merge_q   <= ram_out;
        end
        ST_FAULT: begin
          r_exc_valid  <= 1'b1;
          r_exc_code   <= r_req.we ? EXC_ADES : EXC_ADEL;
          r_resp_rdata <= '0;
        end
        ST_RESP: begin
          r_resp_rdata <= '0;
          r_exc_valid  <= 1'b0;
          r_exc_code   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign busy       = ~req_ready;
  assign resp_valid = (r_state == ST_RESP);
  assign resp_rdata = r_resp_rdata;
  assign exc_valid  = r_exc_valid;
  assign exc_code   = r_exc_code;
  assign ram_now_pc = r_req.pc;
  assign ram_addr   = {r_req.addr[31:2], 2'b00};
  assign ram_data   = (r_state == ST_MERGE) ? w_merged : r_req.wdata;
  // Gating with reset keeps a write from landing on the edge that aborts an access.
  assign ram_isWD   = w_wr_en & reset;

endmodule

// File: tb/tb_dm_rmw_ctrl.sv
// Bench for dm_rmw_ctrl: a behavioural RAM plus a reference memory/response model,
//  directed scenarios followed by randomized accesses.
module tb_dm_rmw_ctrl;

  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] ram_now_pc;
  logic [31:0] ram_addr;
  logic [31:0] ram_data;
  logic        ram_isWD;
  logic [31:0] ram_out;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  int          wr_cnt = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] obs_rdata;

  always #5 clk = ~clk;

  dm_rmw_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_sign   (req_sign),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_pc     (req_pc),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .exc_valid  (exc_valid),
    .exc_code   (exc_code),
    .ram_now_pc (ram_now_pc),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ram_isWD   (ram_isWD),
    .ram_out    (ram_out)
  );

  assign ram_out = mem[ram_addr[13:2]];

  always @(posedge clk) begin
    if (ram_isWD) begin
      mem[ram_addr[13:2]] = ram_data;
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference: access outcome from the byte-addressed semantics, updates ref_mem on stores.
  task automatic model(input logic we, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic exc, output logic [4:0] code, output logic [31:0] rdata,
                       output int lat, output int nwr);
    int          nb;
    int          sh;
    logic [31:0] mask;
    logic [31:0] w;
    logic [31:0] v;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    exc = 1'b0; code = 5'd0; rdata = 32'd0; lat = 2; nwr = 0;
    if ((addr % nb) != 0 || addr >= 32'(4 * DEPTH)) begin
      exc  = 1'b1;
      code = we ? 5'd5 : 5'd4;
      return;
    end
    sh   = 8 * int'(addr % 4);
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    w    = ref_mem[addr / 4];
    if (!we) begin
      v = (w >> sh) & mask;
      if (sign && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
      rdata = v;
    end else begin
      ref_mem[addr / 4] = (w & ~(mask << sh)) | ((wdata & mask) << sh);
      lat = (nb == 4) ? 2 : 3;
      nwr = 1;
    end
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size, input logic sign,
                           input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_sign  = sign;
    req_addr  = addr;
    req_wdata = wdata;
    req_pc    = $urandom;
  endtask

  // Entered and left at posedge+#1 with the controller idle.
  task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                         input logic sign, input logic [31:0] addr, input logic [31:0] wdata);
    logic        e_exc;
    logic [4:0]  e_code;
    logic [31:0] e_rdata;
    logic [31:0] pc;
    int          e_lat, e_nwr, lat, nw, wc;
    drive_req(we, size, sign, addr, wdata);
    pc = req_pc;
    @(negedge clk);
    check_val({tag, "_rdy"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    model(we, size, sign, addr, wdata, e_exc, e_code, e_rdata, e_lat, e_nwr);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_size  = 2'($urandom);
    req_we    = 1'($urandom);
    lat = 0; nw = 0; wc = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check_val({tag, "_rdy_busy"}, 32'({req_ready, busy}), 32'd1);
      if (c == 1) check_val({tag, "_pc"}, ram_now_pc, pc);
      if (ram_isWD) begin
        nw++;
        wc = c;
      end
      if (resp_valid) begin
        lat = c;
        break;
      end
    end
    obs_rdata = resp_rdata;
    check_val({tag, "_lat"}, 32'(lat), 32'(e_lat));
    check_val({tag, "_rdata"}, resp_rdata, e_rdata);
    check_val({tag, "_exc"}, {26'd0, exc_valid, exc_code}, {26'd0, e_exc, e_code});
    check_val({tag, "_nwr"}, 32'(nw), 32'(e_nwr));
    check_val({tag, "_wcyc"}, 32'(wc), 32'((e_nwr != 0) ? e_lat - 1 : 0));
    if (addr < 32'(4 * DEPTH))
      check_val({tag, "_mem"}, mem[addr[13:2]], ref_mem[addr[13:2]]);
    @(posedge clk);
    #1;
    check_val({tag, "_after"}, 32'({resp_valid, req_ready}), 32'd1);
  endtask

  initial begin
    logic        e_exc [3];
    logic [4:0]  e_code [3];
    logic [31:0] e_rdata [3];
    int          e_lat [3];
    int          e_nwr;
    int          acc_c [3];
    int          rsp_c [3];
    int          busy_until;
    int          k, r, w0, diff;
    logic        acc_now;
    logic [31:0] q_addr [3];
    logic [1:0]  q_size [3];
    logic        q_we [3];
    logic [31:0] addr;

    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_sign = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; req_pc = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_out", {resp_rdata[31:0]}, 32'd0);
    check_val("rst_ctl", 32'({resp_valid, exc_valid, exc_code, req_ready, busy, ram_isWD}), 32'b0000000100);
    @(posedge clk);
    #1;
    reset = 1'b1;

    mem[4] = 32'h1122_3344; ref_mem[4] = 32'h1122_3344;
    mem[8] = 32'h0000_F0FF; ref_mem[8] = 32'h0000_F0FF;
    run_req("t1_lb", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    check_val("t1_const", obs_rdata, 32'h0000_0011);
    run_req("t2_sb", 1'b1, 2'd0, 1'b0, 32'h11, 32'hAB);
    check_val("t2_const", mem[4], 32'h1122_AB44);
    run_req("t3_lh", 1'b0, 2'd1, 1'b1, 32'h20, 32'h0);
    check_val("t3_lh_const", obs_rdata, 32'hFFFF_F0FF);
    run_req("t3_lhu", 1'b0, 2'd1, 1'b0, 32'h20, 32'h0);
    check_val("t3_lhu_const", obs_rdata, 32'h0000_F0FF);
    run_req("t4_sw", 1'b1, 2'd2, 1'b0, 32'h22, 32'hDEAD_BEEF);
    run_req("t4_lw", 1'b0, 2'd2, 1'b0, 32'h4000, 32'h0);
    run_req("t4_sz3", 1'b0, 2'd3, 1'b0, 32'h21, 32'h0);

    // Reset lands in the MERGE cycle of a half store.
    w0 = wr_cnt;
    drive_req(1'b1, 2'd1, 1'b0, 32'h16, 32'hBEEF);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_val("t5_wd_in_merge", 32'(ram_isWD), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    check_val("t5_ready", 32'({resp_valid, req_ready}), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check_val("t5_no_resp", 32'({resp_valid, busy}), 32'd0);
    end
    check_val("t5_writes", 32'(wr_cnt - w0), 32'd0);
    check_val("t5_mem", mem[5], ref_mem[5]);
    @(posedge clk);
    #1;

    // Three requests queued behind a held req_valid.
    q_we[0] = 1'b0; q_size[0] = 2'd2; q_addr[0] = 32'h10;
    q_we[1] = 1'b1; q_size[1] = 2'd2; q_addr[1] = 32'h24;
    q_we[2] = 1'b0; q_size[2] = 2'd0; q_addr[2] = 32'h26;
    k = 0; r = 0; busy_until = 0;
    drive_req(q_we[0], q_size[0], 1'b1, q_addr[0], 32'hCAFE_F00D);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      check_val("t6_ready", 32'({req_ready, busy}), (c > busy_until) ? 32'd2 : 32'd1);
      if (resp_valid && r < 3) begin
        rsp_c[r] = c;
        check_val("t6_rdata", resp_rdata, e_rdata[r]);
        check_val("t6_exc", 32'(exc_valid), 32'(e_exc[r]));
        r++;
      end
      acc_now = req_valid && (c > busy_until) && k < 3;
      if (acc_now) begin
        acc_c[k] = c;
        model(q_we[k], q_size[k], 1'b1, q_addr[k], 32'hCAFE_F00D,
              e_exc[k], e_code[k], e_rdata[k], e_lat[k], e_nwr);
        busy_until = c + e_lat[k];
      end
      @(posedge clk);
      #1;
      if (acc_now) begin
        k++;
        if (k < 3) drive_req(q_we[k], q_size[k], 1'b1, q_addr[k], 32'hCAFE_F00D);
        else req_valid = 1'b0;
      end
      if (r == 3) break;
    end
    check_val("t6_count", 32'(r), 32'd3);
    for (int i = 1; i < 3; i++) begin
      check_val("t6_b2b", 32'(acc_c[i]), 32'(rsp_c[i-1] + 1));
      check_val("t6_lat", 32'(rsp_c[i] - acc_c[i]), 32'(e_lat[i]));
    end
    check_val("t6_mem", mem[9], ref_mem[9]);
    req_valid = 1'b0;
    @(posedge clk);
    #1;

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0:       addr = $urandom;
        1:       addr = 32'h3FF0 + 32'($urandom_range(0, 31));
        default: addr = 32'($urandom_range(0, 63));
      endcase
      run_req("rnd", 1'($urandom), 2'($urandom), 1'($urandom), addr, $urandom);
    end

    diff = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) diff++;
    check_val("mem_sweep", 32'(diff), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
